// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage execution unit:
// ALU control codes, FSM state encoding and default width.
package alu_pkg;

   localparam int DATA_W_DEF = 32;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier datapath: one multiplier bit
// per step, low DATA_W bits of the product kept.
module ex_mul_iter
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] prod_o,
   output logic              last_o
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] prod_q, prod_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] addend;
   logic [DATA_W-1:0] prod_next;

   always_comb begin
      addend    = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;
      prod_next = prod_q + addend;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      if (load_i) begin
         mcand_d  = a_i;
         mplier_d = b_i;
         prod_d   = '0;
         cnt_d    = '0;
      end else if (step_i) begin
         prod_d = prod_next;
         cnt_d  = cnt_q + 1'b1;
      end
   end

   // prod_o already includes the current step so the final
   // product is available on the cycle last_o is high.
   assign prod_o = prod_next;
   assign last_o = (cnt_q == CNT_LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/ex_alu_seq.sv
// EX-stage execution unit: single-cycle logic/add ops plus an
// iterative multiply that stalls the pipeline while it runs.
module ex_alu_seq
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] data1_i,
   input  logic [DATA_W-1:0] data2_i,
   input  logic [2:0]        ALUCtrl_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o,
   output logic              done_o,
   output logic              stall_o
);

   alu_state_e        state_q, state_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zero_q, zero_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] single_res;
   logic [DATA_W-1:0] mul_prod;
   logic              mul_last;
   logic              mul_load;
   logic              mul_step;

   always_comb begin
      single_res = '0;
      case (ALUCtrl_i)
         ALU_AND: single_res = data1_i & data2_i;
         ALU_OR:  single_res = data1_i | data2_i;
         ALU_ADD: single_res = data1_i + data2_i;
         ALU_SUB: single_res = data1_i - data2_i;
         default: single_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      mul_load = 1'b0;
      mul_step = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (ALUCtrl_i == ALU_MUL) begin
                  mul_load = 1'b1;
                  state_d  = ST_MUL;
               end else begin
                  result_d = single_res;
                  zero_d   = (single_res == '0);
                  done_d   = 1'b1;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            mul_step = 1'b1;
            if (mul_last) begin
               result_d = mul_prod;
               zero_d   = (mul_prod == '0);
               done_d   = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
      end
   end

   ex_mul_iter #(
      .DATA_W(DATA_W)
   ) u_mul (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .load_i(mul_load),
      .step_i(mul_step),
      .a_i   (data1_i),
      .b_i   (data2_i),
      .prod_o(mul_prod),
      .last_o(mul_last)
   );

   // Gated by reset so the pipeline never sees a stall while held.
   assign stall_o = rst_i &
                    (((state_q == ST_IDLE) & start_i &
                      (ALUCtrl_i == ALU_MUL)) |
                     (state_q == ST_MUL));

   assign result_o = result_q;
   assign zero_o   = zero_q;
   assign done_o   = done_q;

endmodule

// File: tb/tb_ex_alu_seq.sv
// Scoreboard bench for ex_alu_seq: expected results queued at
// issue, popped and compared on each done_o pulse.
module tb_ex_alu_seq;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         start_i = 1'b0;
   logic [W-1:0] data1_i = '0;
   logic [W-1:0] data2_i = '0;
   logic [2:0]   ALUCtrl_i = 3'b000;
   logic [W-1:0] result_o;
   logic         zero_o;
   logic         done_o;
   logic         stall_o;

   typedef struct packed {
      logic [W-1:0] res;
      logic         zero;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   done_cnt = 0;
   int   stall_cnt = 0;

   ex_alu_seq #(.DATA_W(W)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .data1_i  (data1_i),
      .data2_i  (data2_i),
      .ALUCtrl_i(ALUCtrl_i),
      .result_o (result_o),
      .zero_o   (zero_o),
      .done_o   (done_o),
      .stall_o  (stall_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag,
                      input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (stall_o === 1'b1) stall_cnt++;
      if (done_o === 1'b1) begin
         done_cnt++;
         chk("sb_nonempty", W'(sb.size() != 0), W'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("result", result_o, e.res);
            chk("zero", W'(zero_o), W'(e.zero));
         end
      end
   end

   task automatic run_op(input logic [2:0] c,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [W-1:0] er,
                         input int elat,
                         input int estall,
                         input string tag,
                         input bit poke);
      int   lat;
      int   s0;
      int   d0;
      exp_t e;
      @(posedge clk_i); #1;
      s0 = stall_cnt;
      d0 = done_cnt;
      e.res  = er;
      e.zero = (er == '0);
      sb.push_back(e);
      start_i   = 1'b1;
      ALUCtrl_i = c;
      data1_i   = a;
      data2_i   = b;
      @(posedge clk_i); #1;
      start_i   = 1'b0;
      ALUCtrl_i = ALU_AND;
      data1_i   = $urandom;
      data2_i   = $urandom;
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
         if (poke && lat == 5) begin
            start_i   = 1'b1;
            ALUCtrl_i = ALU_ADD;
            data1_i   = 1;
            data2_i   = 1;
         end
         if (poke && lat == 6) start_i = 1'b0;
      end while (done_o !== 1'b1 && lat < 100);
      chk({tag, "_lat"}, W'(lat), W'(elat));
      repeat (3) @(negedge clk_i);
      chk({tag, "_stall"}, W'(stall_cnt - s0), W'(estall));
      chk({tag, "_dones"}, W'(done_cnt - d0), W'(1));
      chk({tag, "_sb"}, W'(sb.size()), W'(0));
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           d0;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] p;

      repeat (3) @(posedge clk_i);
      #1;
      start_i   = 1'b1;
      ALUCtrl_i = ALU_MUL;
      @(negedge clk_i);
      chk("rst_result", result_o, '0);
      chk("rst_zero", W'(zero_o), W'(0));
      chk("rst_done", W'(done_o), W'(0));
      chk("rst_stall", W'(stall_o), W'(0));
      start_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;

      run_op(ALU_ADD, 5, 7, 12, 1, 0, "add", 1'b0);
      run_op(ALU_SUB, 9, 9, 0, 1, 0, "sub0", 1'b0);
      run_op(ALU_SUB, 0, 1, 32'hFFFF_FFFF, 1, 0, "subw", 1'b0);
      run_op(ALU_AND, 32'hF0, 32'h3C, 32'h30, 1, 0, "and", 1'b0);
      run_op(ALU_OR, 32'hF0, 32'h0F, 32'hFF, 1, 0, "or", 1'b0);
      run_op(3'b111, 32'h55, 32'hAA, 0, 1, 0, "undef", 1'b0);
      run_op(ALU_MUL, 7, 6, 42, 33, 33, "mul", 1'b0);
      run_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
             33, 33, "mulneg", 1'b0);
      run_op(ALU_MUL, 7, 6, 42, 33, 33, "mulpoke", 1'b1);

      for (int i = 0; i < 3; i++) begin
         a = $urandom;
         b = $urandom;
         p = a * b;
         run_op(ALU_MUL, a, b, p, 33, 33, "mulrnd", 1'b0);
         run_op(ALU_ADD, a, b, a + b, 1, 0, "addrnd", 1'b0);
      end

      @(posedge clk_i); #1;
      d0 = done_cnt;
      start_i   = 1'b1;
      ALUCtrl_i = ALU_MUL;
      data1_i   = 7;
      data2_i   = 6;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (10) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("abort_result", result_o, '0);
      chk("abort_zero", W'(zero_o), W'(0));
      chk("abort_done", W'(done_o), W'(0));
      chk("abort_stall", W'(stall_o), W'(0));
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      repeat (40) @(negedge clk_i);
      chk("abort_nodone", W'(done_cnt - d0), W'(0));
      run_op(ALU_ADD, 2, 3, 5, 1, 0, "addpost", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
